conv_addr_fsm: RTL and testbench
================================

// Module: conv_addr_fsm
// PURPOSE
//  Address/sequencing FSM for N_CONV parallel 2-D convolvers sharing one line-buffer address space.
//  Drives read/write addresses for image-column load, convolution processing and per-convolver readout.
//  Sits between the host register interface (i_load/i_SoP/i_valid) and the BRAM/convolver datapath.
//  Generalises the single-convolver FSM: kernel size, convolver count and pipeline latency are parameters.
//  Adds an explicit readout block counter, an abort path and an error flag.
// PARAMETERS
//  NB_ADDRESS  10  address counter width
//  NB_IMAGE    10  width of i_imgLength
//  N_CONV      4   number of convolvers, which is also the number of readout blocks after processing
//  LATENCIA    5   convolver pipeline latency in cycles, from read address to first valid result
//  KERNEL      3   kernel side; valid output columns = i_imgLength-(KERNEL-1)
//  NB_CNT      $clog2(N_CONV+1)  pending-block counter width (derived)
// PORTS
//  i_CLK          in   1           clock; all state updates on rising edge
//  i_reset        in   1           asynchronous, active-low reset
//  i_imgLength    in   NB_IMAGE    last column index (columns 0..i_imgLength)
//  i_load         in   1           host request: load a column block
//  i_SoP          in   1           host request: start of processing, level held for the whole run
//  i_valid        in   1           host data strobe; only its rising edge counts
//  o_readAdd      out  NB_ADDRESS  read address (rd counter)
//  o_writeAdd     out  NB_ADDRESS  wr counter while o_sopross=1, else rd counter
//  o_changeBlock  out  1           one-cycle pulse: block finished
//  o_fsm2convVld  out  1           convolver input valid
//  o_sopross      out  1           processing in progress
//  o_EoP          out  1           end of process: readout blocks pending (pending!=0)
//  o_pending      out  NB_CNT      readout blocks remaining
//  o_err          out  1           one-cycle pulse: illegal request or abort
// BEHAVIOUR
//  Reset (i_reset=0, async): state IDLE. rd, wr, pending and valid_q are 0. All outputs are 0.
//  Valid rise: v_rise = i_valid & ~valid_q, with valid_q registered every cycle.
//  States: IDLE, LOAD, PROC, DONE, READ.
//  IDLE: rd=wr=0. Requests are checked in this priority order:
//   - i_load&i_SoP: o_err pulse, stay IDLE.
//   - pending!=0 & ~i_load & ~i_SoP: go READ, pending--.
//   - i_load & pending==0: go LOAD.
//   - i_SoP & pending==0: go PROC; o_sopross<=1, o_fsm2convVld<=1.
//   - Any other input: stay IDLE; a request made while pending!=0 is ignored.
//  LOAD: on v_rise, if rd==i_imgLength: o_changeBlock pulse, go IDLE. Otherwise rd++.
//   Without v_rise, rd holds.
//  READ: same as LOAD, but the terminal value is rd==i_imgLength-(KERNEL-1).
//  PROC (free-running, ignores i_valid):
//   - rd++ each cycle while rd<i_imgLength, then saturates.
//   - wr++ on each edge where rd>=LATENCIA and wr<i_imgLength-(KERNEL-1).
//   - o_fsm2convVld<=0 on the edge where wr goes from i_imgLength-KERNEL to i_imgLength-(KERNEL-1).
//   - When wr==i_imgLength-(KERNEL-1): o_changeBlock pulse, go DONE.
//   - ~i_SoP in PROC aborts: o_err pulse, go IDLE, vld=sopross=0, pending stays 0.
//  DONE: pending<=N_CONV, o_sopross<=0, o_fsm2convVld=0. Wait for ~i_SoP, then go IDLE.
//  o_changeBlock and o_err are never high for two consecutive cycles.
//  Widths: i_imgLength is zero-extended to NB_ADDRESS. All subtractions are done in NB_ADDRESS+1 bits.
//   If i_imgLength<KERNEL, the terminal value is 0: PROC goes to DONE on its first edge, READ ends on the first v_rise.
//  Latency: first wr increment lands LATENCIA+1 edges after PROC entry.
//  Addresses are registered outputs; the only combinational output logic is the o_writeAdd mux.
// TESTING (N_CONV=4, LATENCIA=5, KERNEL=3, i_imgLength=10)
//  Reset: pull i_reset low in LOAD with rd=4 -> all outputs 0 immediately (no clock); IDLE after release.
//  Load: i_load=1, 11 i_valid rises, one held high 3 cycles -> rd 0..10 (held pulse counts once); changeBlock pulses on 11th rise.
//  Process: i_SoP=1 -> sopross=vld=1; rd 0..10 then saturates; wr 0..8 starting at edge 6; vld drops on wr 7->8; changeBlock pulse; pending=4, EoP=1.
//  Readout: drop i_SoP, then 4 x (9 v_rise) -> pending 3,2,1,0 on READ entries; changeBlock after each block; EoP=0 at end.
//  Errors: i_load=i_SoP=1 in IDLE -> err pulse, no state change; drop i_SoP at rd=3 in PROC -> err pulse, IDLE, vld=0, pending=0.
//  Degenerate: i_imgLength=1 -> PROC reaches DONE in 1 edge; each READ ends on its first v_rise.

Source files
------------

// File: rtl/conv_addr_fsm.sv
// Address and sequencing FSM for N_CONV parallel 2-D convolvers sharing one
// line-buffer address space: column load, convolution processing and
// per-convolver readout, plus an abort path and an error pulse.
module conv_addr_fsm #(
  parameter int NB_ADDRESS = 10,
  parameter int NB_IMAGE   = 10,
  parameter int N_CONV     = 4,
  parameter int LATENCIA   = 5,
  parameter int KERNEL     = 3,
  parameter int NB_CNT     = $clog2(N_CONV + 1)
) (
  input  logic                  i_CLK,
  input  logic                  i_reset,
  input  logic [NB_IMAGE-1:0]   i_imgLength,
  input  logic                  i_load,
  input  logic                  i_SoP,
  input  logic                  i_valid,
  output logic [NB_ADDRESS-1:0] o_readAdd,
  output logic [NB_ADDRESS-1:0] o_writeAdd,
  output logic                  o_changeBlock,
  output logic                  o_fsm2convVld,
  output logic                  o_sopross,
  output logic                  o_EoP,
  output logic [NB_CNT-1:0]     o_pending,
  output logic                  o_err
);

  typedef enum logic [2:0] {IDLE, LOAD, PROC, DONE, READ} state_t;

  localparam logic [NB_ADDRESS-1:0] ONE_A    = NB_ADDRESS'(1);
  localparam logic [NB_ADDRESS-1:0] LAT_A    = NB_ADDRESS'(LATENCIA);
  localparam logic [NB_ADDRESS:0]   KM1_W    = (NB_ADDRESS + 1)'(KERNEL - 1);
  localparam logic [NB_CNT-1:0]     ONE_C    = NB_CNT'(1);
  localparam logic [NB_CNT-1:0]     NCONV_C  = NB_CNT'(N_CONV);

  state_t                  state, state_n;
  logic [NB_ADDRESS-1:0]   rd, rd_n;
  logic [NB_ADDRESS-1:0]   wr, wr_n;
  logic [NB_CNT-1:0]       pending, pending_n;
  logic                    valid_q;
  logic                    change_q, change_n;
  logic                    err_q, err_n;
  logic                    sop_q, sop_n;
  logic                    vld_q, vld_n;
  logic                    eop_q, eop_n;

  logic [NB_ADDRESS-1:0]   img_ext;
  logic [NB_ADDRESS:0]     col_diff;
  logic [NB_ADDRESS-1:0]   term;
  logic                    v_rise;

  // Last valid output column; a negative difference (tiny image) clamps to 0
  always_comb begin
    img_ext  = NB_ADDRESS'(i_imgLength);
    col_diff = {1'b0, img_ext} - KM1_W;
    term     = col_diff[NB_ADDRESS] ? '0 : col_diff[NB_ADDRESS-1:0];
    v_rise   = i_valid & ~valid_q;
  end

  // State and registered outputs, cleared asynchronously by the active-low reset
  always_ff @(posedge i_CLK or negedge i_reset) begin
    if (!i_reset) begin
      state    <= IDLE;
      rd       <= '0;
      wr       <= '0;
      pending  <= '0;
      valid_q  <= 1'b0;
      change_q <= 1'b0;
      err_q    <= 1'b0;
      sop_q    <= 1'b0;
      vld_q    <= 1'b0;
      eop_q    <= 1'b0;
    end else begin
      state    <= state_n;
      rd       <= rd_n;
      wr       <= wr_n;
      pending  <= pending_n;
      valid_q  <= i_valid;
      change_q <= change_n;
      err_q    <= err_n;
      sop_q    <= sop_n;
      vld_q    <= vld_n;
      eop_q    <= eop_n;
    end
  end

  // Next-state, counter and pulse logic; pulses default low every cycle
  always_comb begin
    state_n   = state;
    rd_n      = rd;
    wr_n      = wr;
    pending_n = pending;
    change_n  = 1'b0;
    err_n     = 1'b0;
    sop_n     = sop_q;
    vld_n     = vld_q;
    case (state)
      IDLE: begin
        rd_n = '0;
        wr_n = '0;
        if (i_load && i_SoP) begin
          err_n = ~err_q;
        end else if ((pending != '0) && !i_load && !i_SoP) begin
          state_n   = READ;
          pending_n = pending - ONE_C;
        end else if (i_load && (pending == '0)) begin
          state_n = LOAD;
        end else if (i_SoP && (pending == '0)) begin
          state_n = PROC;
          sop_n   = 1'b1;
          vld_n   = 1'b1;
        end
      end
      LOAD: begin
        if (v_rise) begin
          if (rd == img_ext) begin
            change_n = 1'b1;
            state_n  = IDLE;
            rd_n     = '0;
          end else begin
            rd_n = rd + ONE_A;
          end
        end
      end
      READ: begin
        if (v_rise) begin
          if (rd == term) begin
            change_n = 1'b1;
            state_n  = IDLE;
            rd_n     = '0;
          end else begin
            rd_n = rd + ONE_A;
          end
        end
      end
      PROC: begin
        if (!i_SoP) begin
          err_n   = ~err_q;
          state_n = IDLE;
          sop_n   = 1'b0;
          vld_n   = 1'b0;
          rd_n    = '0;
          wr_n    = '0;
        end else if (wr == term) begin
          change_n = 1'b1;
          state_n  = DONE;
        end else begin
          if (rd < img_ext) begin
            rd_n = rd + ONE_A;
          end
          if ((rd >= LAT_A) && (wr < term)) begin
            wr_n = wr + ONE_A;
            if ((wr + ONE_A) == term) begin
              vld_n = 1'b0;
            end
          end
        end
      end
      DONE: begin
        pending_n = NCONV_C;
        sop_n     = 1'b0;
        vld_n     = 1'b0;
        if (!i_SoP) begin
          state_n = IDLE;
          rd_n    = '0;
          wr_n    = '0;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
    eop_n = (pending_n != '0);
  end

  // Write address follows the write counter only while processing
  always_comb begin
    o_writeAdd = sop_q ? wr : rd;
  end

  assign o_readAdd     = rd;
  assign o_changeBlock = change_q;
  assign o_fsm2convVld = vld_q;
  assign o_sopross     = sop_q;
  assign o_EoP         = eop_q;
  assign o_pending     = pending;
  assign o_err         = err_q;

endmodule

// File: tb/tb_conv_addr_fsm.sv
// Self-checking bench for conv_addr_fsm: randomized column loads, processing
// runs and readouts compared against closed-form expectations.
module tb_conv_addr_fsm;

  localparam int NB_ADDRESS = 10;
  localparam int NB_IMAGE   = 10;
  localparam int N_CONV     = 4;
  localparam int LATENCIA   = 5;
  localparam int KERNEL     = 3;
  localparam int NB_CNT     = $clog2(N_CONV + 1);

  logic                  i_CLK;
  logic                  i_reset;
  logic [NB_IMAGE-1:0]   i_imgLength;
  logic                  i_load;
  logic                  i_SoP;
  logic                  i_valid;
  logic [NB_ADDRESS-1:0] o_readAdd;
  logic [NB_ADDRESS-1:0] o_writeAdd;
  logic                  o_changeBlock;
  logic                  o_fsm2convVld;
  logic                  o_sopross;
  logic                  o_EoP;
  logic [NB_CNT-1:0]     o_pending;
  logic                  o_err;

  int testsRun    = 0;
  int testsFailed = 0;

  conv_addr_fsm #(
    .NB_ADDRESS(NB_ADDRESS), .NB_IMAGE(NB_IMAGE), .N_CONV(N_CONV),
    .LATENCIA(LATENCIA), .KERNEL(KERNEL)
  ) dut (
    .i_CLK(i_CLK), .i_reset(i_reset), .i_imgLength(i_imgLength),
    .i_load(i_load), .i_SoP(i_SoP), .i_valid(i_valid),
    .o_readAdd(o_readAdd), .o_writeAdd(o_writeAdd),
    .o_changeBlock(o_changeBlock), .o_fsm2convVld(o_fsm2convVld),
    .o_sopross(o_sopross), .o_EoP(o_EoP), .o_pending(o_pending), .o_err(o_err)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial i_CLK = 1'b0;
  always #5 i_CLK = ~i_CLK;

  // Compares one observed value with its expected value and logs mismatches
  task automatic checkOutput(input string tag, input int got, input int exp);
    testsRun++;
    if (got != exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drives the host inputs, then advances one rising edge and settles 1 time unit
  task automatic applyStimulus(input logic load, input logic sop, input logic valid);
    i_load  = load;
    i_SoP   = sop;
    i_valid = valid;
    @(posedge i_CLK);
    #1;
  endtask

  // Last valid output column for a given last column index
  function automatic int termOf(input int img);
    return (img >= KERNEL - 1) ? img - (KERNEL - 1) : 0;
  endfunction

  function automatic int minInt(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int maxInt(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // One strobe: rising edge, random extra hold, random low gap
  task automatic sendStrobe(input string tag, input int expChange);
    int hold;
    int gap;
    hold = $urandom_range(1, 3);
    gap  = $urandom_range(1, 2);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput(tag, o_changeBlock, expChange);
    repeat (hold - 1) applyStimulus(1'b0, 1'b0, 1'b1);
    repeat (gap) applyStimulus(1'b0, 1'b0, 1'b0);
  endtask

  // Column load: one address step per strobe rise, block ends after column img
  task automatic runLoad(input int img);
    i_imgLength = NB_IMAGE'(img);
    applyStimulus(1'b1, 1'b0, 1'b0);
    for (int c = 0; c <= img; c++) begin
      checkOutput("load_rd", o_readAdd, c);
      checkOutput("load_wradd", o_writeAdd, c);
      sendStrobe("load_change", (c == img) ? 1 : 0);
    end
    checkOutput("load_change_clear", o_changeBlock, 0);
    checkOutput("load_pending", o_pending, 0);
  endtask

  // Processing run: addresses follow closed-form curves of edges since entry
  task automatic runProc(input int img);
    int term;
    int doneEdge;
    term     = termOf(img);
    doneEdge = (term == 0) ? 1 : term + LATENCIA + 1;
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("proc_sop_entry", o_sopross, 1);
    checkOutput("proc_vld_entry", o_fsm2convVld, 1);
    checkOutput("proc_rd_entry", o_readAdd, 0);
    checkOutput("proc_wr_entry", o_writeAdd, 0);
    for (int k = 1; k < doneEdge; k++) begin
      applyStimulus(1'b0, 1'b1, 1'b0);
      checkOutput("proc_rd", o_readAdd, minInt(k, img));
      checkOutput("proc_wr", o_writeAdd, minInt(maxInt(k - LATENCIA, 0), term));
      checkOutput("proc_vld", o_fsm2convVld, (k < term + LATENCIA) ? 1 : 0);
      checkOutput("proc_change_early", o_changeBlock, 0);
    end
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("proc_change", o_changeBlock, 1);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("proc_change_clear", o_changeBlock, 0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("done_pending", o_pending, N_CONV);
    checkOutput("done_eop", o_EoP, 1);
    checkOutput("done_sop", o_sopross, 0);
    checkOutput("done_vld", o_fsm2convVld, 0);
    checkOutput("done_err", o_err, 0);
  endtask

  // Readout: a load request while blocks are pending is ignored, then N_CONV blocks
  task automatic runReadout(input int img);
    int term;
    term = termOf(img);
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("ignore_load_pending", o_pending, N_CONV);
    checkOutput("ignore_load_rd", o_readAdd, 0);
    checkOutput("ignore_load_eop", o_EoP, 1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    for (int b = 0; b < N_CONV; b++) begin
      checkOutput("read_pending", o_pending, N_CONV - 1 - b);
      checkOutput("read_eop", o_EoP, (N_CONV - 1 - b != 0) ? 1 : 0);
      for (int c = 0; c <= term; c++) begin
        checkOutput("read_rd", o_readAdd, c);
        sendStrobe("read_change", (c == term) ? 1 : 0);
      end
    end
    checkOutput("read_end_pending", o_pending, 0);
    checkOutput("read_end_eop", o_EoP, 0);
  endtask

  initial begin
    int imgs[5];
    i_reset     = 1'b0;
    i_load      = 1'b0;
    i_SoP       = 1'b0;
    i_valid     = 1'b0;
    i_imgLength = NB_IMAGE'(10);
    #1;
    checkOutput("reset_rd", o_readAdd, 0);
    checkOutput("reset_pending", o_pending, 0);
    checkOutput("reset_sop", o_sopross, 0);
    repeat (2) @(posedge i_CLK);
    #1;
    i_reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0);

    // Illegal simultaneous request: one error pulse, no state change
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("err_idle", o_err, 1);
    checkOutput("err_idle_sop", o_sopross, 0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("err_no_repeat", o_err, 0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("err_idle_after", o_err, 0);
    checkOutput("err_idle_rd", o_readAdd, 0);
    checkOutput("err_idle_pending", o_pending, 0);

    // Abort during processing after three edges
    i_imgLength = NB_IMAGE'(10);
    applyStimulus(1'b0, 1'b1, 1'b0);
    repeat (3) applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("abort_rd", o_readAdd, 3);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("abort_err", o_err, 1);
    checkOutput("abort_vld", o_fsm2convVld, 0);
    checkOutput("abort_sop", o_sopross, 0);
    checkOutput("abort_pending", o_pending, 0);
    checkOutput("abort_eop", o_EoP, 0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("abort_err_clear", o_err, 0);

    // Asynchronous reset in the middle of a load, no clock edge involved
    applyStimulus(1'b1, 1'b0, 1'b0);
    repeat (4) sendStrobe("pre_reset_change", 0);
    checkOutput("pre_reset_rd", o_readAdd, 4);
    i_reset = 1'b0;
    #1;
    checkOutput("async_rd", o_readAdd, 0);
    checkOutput("async_wr", o_writeAdd, 0);
    checkOutput("async_change", o_changeBlock, 0);
    checkOutput("async_vld", o_fsm2convVld, 0);
    checkOutput("async_sop", o_sopross, 0);
    checkOutput("async_eop", o_EoP, 0);
    checkOutput("async_pending", o_pending, 0);
    checkOutput("async_err", o_err, 0);
    @(posedge i_CLK);
    #1;
    i_reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("post_reset_rd", o_readAdd, 0);
    applyStimulus(1'b0, 1'b0, 1'b0);

    // Full flows: nominal length, degenerate length, then random lengths
    imgs[0] = 10;
    imgs[1] = 1;
    for (int i = 2; i < 5; i++) imgs[i] = $urandom_range(5, 30);
    foreach (imgs[i]) begin
      runLoad(imgs[i]);
      runProc(imgs[i]);
      runReadout(imgs[i]);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
